prog_mod_counter: RTL and testbench

//  Programmable-modulus up/down counter; parametrised successor to the fixed 4-bit modulo counter.

---
 rtl/counter_pkg.sv | 17 +
 rtl/prog_mod_counter_if.sv | 34 +++
 rtl/prog_mod_counter_next.sv | 49 ++++
 rtl/prog_mod_counter.sv | 57 +++++
 tb/tb_prog_mod_counter.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared counter encodings and the modulus/terminal helper for counter and timer blocks.
// Optional saturation is enabled with PROG_MOD_COUNTER_SAT_EN.
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // mod_val of 0 stands for the full 2^width range
    function automatic logic [31:0] term_of(input logic [31:0] mod_val,
                                            input int unsigned width);
        if (mod_val == 32'd0)
            return 32'hFFFF_FFFF >> (32 - width);
        else
            return mod_val - 32'd1;
    endfunction

endpackage

// File: rtl/prog_mod_counter_if.sv
// Control/status bundle of the programmable-modulus counter.
// The sat input exists only when PROG_MOD_COUNTER_SAT_EN is defined.
interface prog_mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] mod_val;
`ifdef PROG_MOD_COUNTER_SAT_EN
    logic             sat;
`endif
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             at_term;

    modport master (
        output en, up_dn, load, load_val, mod_val,
`ifdef PROG_MOD_COUNTER_SAT_EN
        output sat,
`endif
        input  count, wrap, at_term
    );

    modport slave (
        input  en, up_dn, load, load_val, mod_val,
`ifdef PROG_MOD_COUNTER_SAT_EN
        input  sat,
`endif
        output count, wrap, at_term
    );

endinterface

// File: rtl/prog_mod_counter_next.sv
// Next-count and wrap computation for one enabled step (combinational).
// Saturating behaviour is compiled in with PROG_MOD_COUNTER_SAT_EN.
module mod_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] term,
    input  logic             up_dn,
`ifdef PROG_MOD_COUNTER_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_nxt
);

    logic hold_at_end;

`ifdef PROG_MOD_COUNTER_SAT_EN
    assign hold_at_end = sat;
`else
    assign hold_at_end = 1'b0;
`endif

    always_comb begin
        next_count = count;
        wrap_nxt   = 1'b0;
        if (up_dn == DIR_UP) begin
            // count above T happens when M is lowered mid-count
            if (count >= term) begin
                next_count = hold_at_end ? term : '0;
                wrap_nxt   = !hold_at_end;
            end else begin
                next_count = count + 1'b1;
            end
        end else begin
            if (count == '0) begin
                next_count = hold_at_end ? '0 : term;
                wrap_nxt   = !hold_at_end;
            end else if (count > term) begin
                next_count = term;
            end else begin
                next_count = count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/prog_mod_counter.sv
// Programmable-modulus up/down counter with load, enable and registered wrap pulse.
// Define PROG_MOD_COUNTER_SAT_EN to add the sat (saturate instead of wrap) input.
module prog_mod_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    prog_mod_counter_if.slave bus
);

    logic [WIDTH-1:0] count_q;
    logic             wrap_q;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_count;
    logic             wrap_nxt;

    assign term = WIDTH'(term_of(32'(bus.mod_val), WIDTH));
    assign load_clamped = (bus.load_val > term) ? term : bus.load_val;

    mod_next_calc #(
        .WIDTH(WIDTH)
    ) u_next (
        .count     (count_q),
        .term      (term),
        .up_dn     (bus.up_dn),
`ifdef PROG_MOD_COUNTER_SAT_EN
        .sat       (bus.sat),
`endif
        .next_count(next_count),
        .wrap_nxt  (wrap_nxt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= RST_VAL;
            wrap_q  <= 1'b0;
        end else if (bus.load) begin
            count_q <= load_clamped;
            wrap_q  <= 1'b0;
        end else if (bus.en) begin
            count_q <= next_count;
            wrap_q  <= wrap_nxt;
        end else begin
            wrap_q  <= 1'b0;
        end
    end

    assign bus.count   = count_q;
    assign bus.wrap    = wrap_q;
    assign bus.at_term = (bus.up_dn == DIR_UP) ? (count_q == term)
                                               : (count_q == '0);

endmodule

// File: tb/tb_prog_mod_counter.sv
// Scoreboard bench for prog_mod_counter; sat cases run when PROG_MOD_COUNTER_SAT_EN is defined.
`timescale 1ns/1ps
module tb_prog_mod_counter;

    localparam int W = 4;

    typedef struct {
        int   c;
        logic w;
        logic t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   m_count = 0;
    exp_t sb[$];

    prog_mod_counter_if #(.WIDTH(W)) bus ();

    prog_mod_counter #(
        .WIDTH  (W),
        .RST_VAL(4'd0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic ud, input logic ld,
                        input int lv, input int mv, input logic st);
        exp_t x;
        int   m;
        int   t;
        bus.en       = e;
        bus.up_dn    = ud;
        bus.load     = ld;
        bus.load_val = W'(lv);
        bus.mod_val  = W'(mv);
`ifdef PROG_MOD_COUNTER_SAT_EN
        bus.sat      = st;
`endif
        m = (mv == 0) ? (1 << W) : mv;
        t = m - 1;
        x.w = 1'b0;
        if (ld) begin
            m_count = (lv > t) ? t : lv;
        end else if (e && ud) begin
            if (m_count >= t) begin
                x.w     = !st;
                m_count = st ? t : 0;
            end else begin
                m_count = m_count + 1;
            end
        end else if (e) begin
            if (m_count == 0) begin
                x.w     = !st;
                m_count = st ? 0 : t;
            end else if (m_count > t) begin
                m_count = t;
            end else begin
                m_count = m_count - 1;
            end
        end
        x.c = m_count;
        x.t = ud ? (m_count == t) : (m_count == 0);
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk("count", int'(bus.count), x.c);
        chk("wrap", int'(bus.wrap), int'(x.w));
        chk("at_term", int'(bus.at_term), int'(x.t));
    endtask

    initial begin
        bus.en       = 1'b0;
        bus.up_dn    = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.mod_val  = '0;
`ifdef PROG_MOD_COUNTER_SAT_EN
        bus.sat      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_wrap", int'(bus.wrap), 0);
        rst = 1'b1;
        m_count = 0;

        // count up to 7, then async reset mid-cycle
        repeat (7) step(1, 1, 0, 0, 10, 0);
        #2 rst = 1'b0;
        #1;
        chk("async_count", int'(bus.count), 0);
        chk("async_wrap", int'(bus.wrap), 0);
        bus.en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("held_count", int'(bus.count), 0);
        chk("held_wrap", int'(bus.wrap), 0);
        rst = 1'b1;
        m_count = 0;

        // modulo-10 up, 12 steps through the wrap
        repeat (12) step(1, 1, 0, 0, 10, 0);

        // full range down from 0
        step(1, 0, 1, 0, 0, 0);
        repeat (3) step(1, 0, 0, 0, 0, 0);

        // load clamp beats en, then hold with en=0
        step(1, 1, 1, 12, 10, 0);
        repeat (2) step(0, 1, 0, 0, 10, 0);
        step(0, 1, 1, 3, 10, 0);

        // lowered modulus, up then down
        step(0, 1, 1, 8, 10, 0);
        step(1, 1, 0, 0, 5, 0);
        step(0, 1, 1, 8, 10, 0);
        step(1, 0, 0, 0, 5, 0);

        // M=1 gives a wrap on every enabled edge
        repeat (3) step(1, 1, 0, 0, 1, 0);
        repeat (2) step(1, 0, 0, 0, 1, 0);

        // random mix
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), 0);

`ifdef PROG_MOD_COUNTER_SAT_EN
        step(0, 1, 1, 0, 6, 1);
        repeat (8) step(1, 1, 0, 0, 6, 1);
        repeat (8) step(1, 0, 0, 0, 6, 1);
        for (int i = 0; i < 40; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                 1'($urandom));
`endif

        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
